ram_arbiter: RTL and testbench

Two-requester front end for the single-port synchronous RAM. It shares the RAM's one port between requesters A and B using round-robin arbitration. After every reset it zero-fills the whole RAM before granting any access. Read data is returned to the issuing requester with a fixed latency and a tag-steered valid strobe.

---
 rtl/ram_arbiter.sv | 116 +++++++++++
 tb/tb_ram_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin front end sharing one single-port synchronous RAM between requesters A and B.
// Zero-fills the RAM after every reset, then steers read data back with a 2-cycle latency.
module ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  prio_b_q;  // 0: A wins a tie, 1: B wins a tie
    logic                  init_done_q;
    logic                  a_tag_q, b_tag_q;
    logic                  a_rvalid_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
    logic                  run;

    assign run = (state_q == StRun);

    always_comb begin
        a_gnt = run & a_req & (~b_req | ~prio_b_q);
        b_gnt = run & b_req & (~a_req | prio_b_q);
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!run) begin
            ram_we   = 1'b1;
            ram_addr = clr_addr_q;
        end else if (a_gnt) begin
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (b_gnt) begin
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StClear;
            clr_addr_q  <= '0;
            prio_b_q    <= 1'b0;
            init_done_q <= 1'b0;
            a_tag_q     <= 1'b0;
            b_tag_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            // Tag stage 1 marks whose read address is on the RAM; stage 2 is the rvalid strobe.
            a_tag_q    <= a_gnt & ~a_we;
            b_tag_q    <= b_gnt & ~b_we;
            a_rvalid_q <= a_tag_q;
            b_rvalid_q <= b_tag_q;
            if (a_tag_q) begin
                a_rdata_q <= ram_rdata;
            end
            if (b_tag_q) begin
                b_rdata_q <= ram_rdata;
            end

            if (state_q == StClear) begin
                clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == LastAddr) begin
                    state_q     <= StRun;
                    init_done_q <= 1'b1;
                end
            end else begin
                if (a_gnt) begin
                    prio_b_q <= 1'b1;
                end else if (b_gnt) begin
                    prio_b_q <= 1'b0;
                end
            end
        end
    end

    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, hand-written reset/clear sequences and
// constrained-random traffic checked every cycle against a transaction-level model.
module tb_ram_arbiter;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr, ram_addr;
    logic [DW-1:0] a_wdata, b_wdata, ram_wdata, ram_rdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, init_done;
    logic [DW-1:0] a_rdata, b_rdata;

    // Environment RAM starts full of garbage so the clear sweep is observable.
    logic [DW-1:0] ram_mem [DEPTH] = '{default: 8'hFF};

    int errs   = 0;
    int checks = 0;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: contents, whose turn it is, and reads awaiting return.
    typedef struct {
        logic          to_b;
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    ret_t          pend[$];
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clr;
    logic          m_turn_a;
    logic [DW-1:0] m_a_rd, m_b_rd;
    int            cyc;

    task automatic monitor();
        logic          ea, eb, era, erb, e_we, in_run;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        m_clr = 0; m_turn_a = 1'b1; m_a_rd = '0; m_b_rd = '0; cyc = 0;
        forever begin
            @(negedge clk);
            era = 1'b0; erb = 1'b0;
            foreach (pend[i]) begin
                if (pend[i].due == cyc) begin
                    if (pend[i].to_b) begin erb = 1'b1; m_b_rd = pend[i].data; end
                    else begin era = 1'b1; m_a_rd = pend[i].data; end
                end
            end
            in_run = (m_clr >= int'(DEPTH));
            ea = 1'b0; eb = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
            if (!in_run) begin
                e_we = 1'b1; e_addr = AW'(m_clr);
            end else if (a_req && b_req) begin
                ea = m_turn_a; eb = !m_turn_a;
            end else begin
                ea = a_req; eb = b_req;
            end
            if (ea) begin e_we = a_we; e_addr = a_addr; e_wd = a_wdata; end
            if (eb) begin e_we = b_we; e_addr = b_addr; e_wd = b_wdata; end

            check("mon_gnt", {a_gnt, b_gnt}, {ea, eb});
            check("mon_ram", {ram_we, ram_addr, ram_wdata}, {e_we, e_addr, e_wd});
            check("mon_rd", {a_rvalid, b_rvalid, a_rdata, b_rdata}, {era, erb, m_a_rd, m_b_rd});
            check("mon_init", init_done, in_run);

            if (ea) begin
                if (a_we) m_mem[a_addr] = a_wdata;
                else pend.push_back('{1'b0, m_mem[a_addr], cyc + 2});
                m_turn_a = 1'b0;
            end
            if (eb) begin
                if (b_we) m_mem[b_addr] = b_wdata;
                else pend.push_back('{1'b1, m_mem[b_addr], cyc + 2});
                m_turn_a = 1'b1;
            end
            if (!in_run) begin
                m_mem[AW'(m_clr)] = '0;
                m_clr++;
            end
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
            if (rst) begin
                m_clr = 0; m_turn_a = 1'b1; m_a_rd = '0; m_b_rd = '0;
                pend.delete();
            end
            cyc++;
        end
    endtask

    typedef struct {
        logic          ar, aw; logic [AW-1:0] aa; logic [DW-1:0] ad;
        logic          br, bw; logic [AW-1:0] ba; logic [DW-1:0] bd;
        logic          ga, gb, rva, rvb; logic [DW-1:0] rda, rdb;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int   n;
        logic a_took, b_took;
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        //        ar    aw    aa    ad      br    bw    ba    bd     ga    gb    rva   rvb   rda    rdb
        vecs[0]  = '{1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 8'h22};
        vecs[10] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22};
        vecs[11] = '{1'b1, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00};
        vecs[14] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h3C};

        fork monitor(); join_none

        tick(); tick(); rst = 1'b0;

        // Clear sweep; B pulses a write request that must never be granted or land.
        n = 0;
        while (init_done !== 1'b1 && n < 40) begin
            b_req = (n >= 2 && n < 6); b_we = 1'b1; b_addr = 4'd5; b_wdata = 8'h77;
            #2; check("clear_no_gnt", {a_gnt, b_gnt}, 2'b00);
            tick(); n++;
        end
        b_req = 1'b0; b_we = 1'b0;
        check("init_len", n, 16);

        foreach (vecs[i]) begin
            a_req = vecs[i].ar; a_we = vecs[i].aw; a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
            b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
            #2;
            check($sformatf("vec%0d_gnt", i), {a_gnt, b_gnt}, {vecs[i].ga, vecs[i].gb});
            check($sformatf("vec%0d_rvalid", i), {a_rvalid, b_rvalid}, {vecs[i].rva, vecs[i].rvb});
            check($sformatf("vec%0d_rdata", i), {a_rdata, b_rdata}, {vecs[i].rda, vecs[i].rdb});
            tick();
        end

        // Reset the cycle after a read grant: the read never returns, and memory is re-cleared.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_wdata = 8'h5A;
        #2; check("mr_wr_gnt", a_gnt, 1'b1); tick();
        a_we = 1'b0;
        #2; check("mr_rd_gnt", a_gnt, 1'b1); tick();
        a_req = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < 40) begin
            #2; check("mr_no_rvalid", {a_rvalid, b_rvalid}, 2'b00);
            tick(); n++;
        end
        check("mr_init_len", n, 16);
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd4;
        #2; check("mr_rd2_gnt", a_gnt, 1'b1); tick();
        a_req = 1'b0; tick();
        #2; check("mr_rd2_data", {a_rvalid, a_rdata}, {1'b1, 8'h00}); tick();

        // Random traffic obeying the hold-until-granted rule, with occasional withdrawal/reset.
        a_took = 1'b0; b_took = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!a_req || a_took || $urandom_range(0, 15) == 0) begin
                a_req = ($urandom_range(0, 2) != 0); a_we = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
            end
            if (!b_req || b_took || $urandom_range(0, 15) == 0) begin
                b_req = ($urandom_range(0, 2) != 0); b_we = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
            end
            rst = ($urandom_range(0, 249) == 0);
            #2; a_took = a_gnt; b_took = b_gnt;
            tick();
        end

        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        tick(); tick(); tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
